// File: rtl/alu_seq.sv
// Registered three-operand ALU with valid/ready handshakes and an iterative remainder unit for op 11.
// Define ALU_SEQ_ZFLAG_EN to add the registered 'zero' result flag output.
module alu_seq #(
    parameter int W  = 4,
    parameter int RW = 2*W+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  c,
    input  logic [1:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] result,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic          zero,
`endif
    output logic          div0
);

    localparam int CW = $clog2(W+1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [W-1:0]  ra, rb, rc;
    logic [1:0]    rop;
    logic [W-1:0]  rem, quo;
    logic [CW-1:0] cnt;

    logic [RW-1:0] xa, xb, xc;
    logic [W:0]    rem_sh;
    logic [W-1:0]  rem_nx;
    logic [RW-1:0] res_nx;

    assign xa = RW'(ra);
    assign xb = RW'(rb);
    assign xc = RW'(rc);

    // Restoring step; with rb == 0 the subtraction is a no-op, so rem ends up as the dividend.
    assign rem_sh = {rem, quo[W-1]};
    assign rem_nx = W'((rem_sh >= {1'b0, rb}) ? rem_sh - {1'b0, rb} : rem_sh);

    always_comb begin
        res_nx = '0;
        case (rop)
            2'b00: res_nx = (xa + xb) * xc;
            2'b01: res_nx = (xa - xb) ^ xc;
            2'b10: res_nx = xa & (xb | xc);
            2'b11: res_nx = RW'(rem) + xa * xc;
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            div0      <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            zero      <= 1'b0;
`endif
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
            rop       <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra       <= a;
                        rb       <= b;
                        rc       <= c;
                        rop      <= op;
                        rem      <= '0;
                        quo      <= a;
                        // Simple ops take a single pass through CALC with no remainder steps.
                        cnt      <= (op == 2'b11) ? CW'(W) : '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        rem <= rem_nx;
                        quo <= quo << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        result    <= res_nx;
                        div0      <= (rop == 2'b11) && (rb == '0);
`ifdef ALU_SEQ_ZFLAG_EN
                        zero      <= (res_nx == '0);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: W=4 and W=8 instances, latency, backpressure and reset abort.
module tb_alu_seq;

    logic       clk;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, div0;
    logic [3:0] a, b, c;
    logic [1:0] op;
    logic [8:0] result;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, div08;
    logic [7:0]  a8, b8, c8;
    logic [1:0]  op8;
    logic [16:0] result8;
`ifdef ALU_SEQ_ZFLAG_EN
    logic zero, zero8;
`endif

    typedef struct {
        logic [63:0] res;
        logic        d0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_seq #(.W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
`ifdef ALU_SEQ_ZFLAG_EN
        .zero(zero),
`endif
        .div0(div0)
    );

    alu_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c(c8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8),
`ifdef ALU_SEQ_ZFLAG_EN
        .zero(zero8),
`endif
        .div0(div08)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                          input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] z);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << (2*w+1)) - 64'd1;
        case (o)
            2'b00:   r = (x + y) * z;
            2'b01:   r = (x - y) ^ z;
            2'b10:   r = x & (y | z);
            default: r = ((y == 0) ? x : x % y) + x * z;
        endcase
        return r & m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Issue one op on the W=4 instance; called at #1 after a rising edge.
    task automatic do_op(input logic [1:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i,
                         input logic [3:0] c_i, input int lat, input int hold);
        exp_t e;
        int   n;
        e.res = model(4, op_i, 64'(a_i), 64'(b_i), 64'(c_i));
        e.d0  = (op_i == 2'b11) && (b_i == 4'd0);
        sb.push_back(e);
        chk("pre_in_ready", 64'(in_ready), 64'd1);
        op = op_i; a = a_i; b = b_i; c = c_i;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); op = 2'($urandom);
        chk("in_ready_drop", 64'(in_ready), 64'd0);
        chk("no_early_valid", 64'(out_valid), 64'd0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
        chk("latency", 64'(n), 64'(lat));
        e = sb.pop_front();
        chk("result", 64'(result), e.res);
        chk("div0", 64'(div0), 64'(e.d0));
`ifdef ALU_SEQ_ZFLAG_EN
        chk("zero", 64'(zero), 64'(e.res == 0));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); op = 2'($urandom);
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), e.res);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_fall", 64'(out_valid), 64'd0);
        chk("back_idle", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op8(input logic [1:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                          input logic [7:0] c_i, input int lat);
        exp_t e;
        int   n;
        e.res = model(8, op_i, 64'(a_i), 64'(b_i), 64'(c_i));
        e.d0  = (op_i == 2'b11) && (b_i == 8'd0);
        sb.push_back(e);
        op8 = op_i; a8 = a_i; b8 = b_i; c8 = c_i;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid8 && n < 40);
        chk("w8_latency", 64'(n), 64'(lat));
        e = sb.pop_front();
        chk("w8_result", 64'(result8), e.res);
        chk("w8_div0", 64'(div08), 64'(e.d0));
`ifdef ALU_SEQ_ZFLAG_EN
        chk("w8_zero", 64'(zero8), 64'(e.res == 0));
`endif
        @(posedge clk); #1;
        chk("w8_valid_fall", 64'(out_valid8), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; c8 = '0; op8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        do_op(2'b00, 4'd3,  4'd5,  4'd7,  1, 0);
        do_op(2'b01, 4'd1,  4'd2,  4'd3,  1, 0);
        do_op(2'b01, 4'd1,  4'd2,  4'd0,  1, 0);
        do_op(2'b10, 4'hF,  4'h5,  4'h8,  1, 0);
        do_op(2'b11, 4'd13, 4'd4,  4'd15, 5, 0);
        do_op(2'b11, 4'd9,  4'd0,  4'd2,  5, 0);
        do_op(2'b11, 4'd0,  4'd3,  4'd5,  5, 0);
        do_op(2'b11, 4'd15, 4'd15, 4'd0,  5, 0);
        do_op(2'b00, 4'd15, 4'd15, 4'd15, 1, 6);

        // Abort an op 11 during its second CALC cycle.
        op = 2'b11; a = 4'd13; b = 4'd4; c = 4'd15; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_div0", 64'(div0), 64'd0);
        @(posedge clk); #1;
        chk("abort_stays_idle", 64'(out_valid), 64'd0);
        do_op(2'b00, 4'd1, 4'd1, 4'd1, 1, 0);

        do_op8(2'b11, 8'd255, 8'd1,  8'd255, 9);
        do_op8(2'b10, 8'hF0,  8'h0F, 8'h00,  1);
        do_op8(2'b11, 8'd200, 8'd0,  8'd3,   9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
